// File: rtl/byte_serializer.sv
// byte_serializer
// Accepts parallel words over a valid/ready handshake and buffers them in a
// small FIFO. It emits each word one bit per clock on bit_out, qualified by
// bit_valid. A pause input stalls the stream without losing or repeating a bit.
// GAP_CYCLES can insert idle cycles between consecutive words.
module byte_serializer #(
    parameter int unsigned DATA_W     = 8,     // word width, >= 2
    parameter int unsigned FIFO_DEPTH = 4,     // power of 2, >= 2
    parameter bit          MSB_FIRST  = 1'b1,  // 1: bit DATA_W-1 first, 0: bit 0 first
    parameter int unsigned GAP_CYCLES = 0      // idle cycles between words, 0..15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              pause,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              word_done,
    output logic              busy
);

    localparam int unsigned       PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned       CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned       BIT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [BIT_W-1:0]  LAST_IDX = BIT_W'(DATA_W - 1);
    localparam logic [3:0]        GAP_LOAD = 4'(GAP_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Word FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              push;
    logic              pop;
    logic              fifo_nonempty;
    logic [DATA_W-1:0] head;

    // in_ready depends only on the registered count. A word cannot pass
    // through the FIFO in the same cycle it arrives.
    assign in_ready      = (count_q != FULL_CNT);
    assign push          = in_valid && in_ready;
    assign fifo_nonempty = (count_q != '0);
    assign head          = mem_q[rd_ptr_q];

    // FIFO storage: write the incoming word at the write pointer.
    // NOTE: the storage array has no reset. count_q and the pointers decide
    // which entries are live, so stale contents are never read. Leaving it
    // unreset lets the array map onto plain RAM or flops without reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // FIFO bookkeeping. The pointers wrap naturally because the depth is a
    // power of 2. A push and a pop in the same cycle leave count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    state_e            state_q,     state_d;
    logic [DATA_W-1:0] shift_q,     shift_d;
    logic [BIT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [3:0]        gap_q,       gap_d;
    logic              bit_out_q,   bit_out_d;
    logic              bit_valid_q, bit_valid_d;
    logic              word_done_q, word_done_d;
    logic              start_word;

    // Next-state and output decode. bit_cnt_q is the index of the bit now
    // on bit_out. That bit is always emitted once before any pause takes
    // effect, so resuming moves straight to the following bit.
    // NOTE: every signal written here gets a default first. Without the
    // defaults, a path that skips an assignment would infer a latch.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        gap_d       = gap_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        word_done_d = 1'b0;
        start_word  = 1'b0;
        pop         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (fifo_nonempty && !pause) begin
                    start_word = 1'b1;
                end
            end

            SHIFT: begin
                if (!pause) begin
                    if (bit_cnt_q != LAST_IDX) begin
                        // Present the next bit of the current word.
                        bit_cnt_d   = bit_cnt_q + BIT_W'(1);
                        bit_valid_d = 1'b1;
                        word_done_d = (bit_cnt_d == LAST_IDX);
                        if (MSB_FIRST) begin
                            bit_out_d = shift_q[DATA_W-2];
                            shift_d   = shift_q << 1;
                        end else begin
                            bit_out_d = shift_q[1];
                            shift_d   = shift_q >> 1;
                        end
                    end else if (GAP_CYCLES != 0) begin
                        state_d = GAP;
                        gap_d   = GAP_LOAD;
                    end else if (fifo_nonempty) begin
                        // Back-to-back word with no idle bubble.
                        start_word = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            GAP: begin
                // The final gap cycle acts like IDLE. A pause holds the counter.
                if (!pause) begin
                    if (gap_q > 4'd1) begin
                        gap_d = gap_q - 4'd1;
                    end else if (fifo_nonempty) begin
                        start_word = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Pop the head word and present its first bit.
        if (start_word) begin
            pop         = 1'b1;
            shift_d     = head;
            bit_cnt_d   = '0;
            bit_out_d   = MSB_FIRST ? head[DATA_W-1] : head[0];
            bit_valid_d = 1'b1;
            state_d     = SHIFT;
        end
    end

    // State and output registers. Reset aborts any word in flight.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            gap_q       <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_q       <= gap_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            word_done_q <= word_done_d;
        end
    end

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign word_done = word_done_q;
    assign busy      = fifo_nonempty || (state_q != IDLE);

endmodule

// File: tb/tb_byte_serializer.sv
// Directed testbench for byte_serializer. One instance uses the default
// parameters. A second instance runs LSB-first with a two-cycle gap.
module tb_byte_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       pause;
    logic       bit_out;
    logic       bit_valid;
    logic       word_done;
    logic       busy;

    logic       g_valid;
    logic [7:0] g_data;
    logic       g_ready;
    logic       g_pause;
    logic       g_bit;
    logic       g_bvalid;
    logic       g_done;
    logic       g_busy;

    byte_serializer #(
        .DATA_W     (8),
        .FIFO_DEPTH (4),
        .MSB_FIRST  (1'b1),
        .GAP_CYCLES (0)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .pause     (pause),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .word_done (word_done),
        .busy      (busy)
    );

    byte_serializer #(
        .DATA_W     (8),
        .FIFO_DEPTH (4),
        .MSB_FIRST  (1'b0),
        .GAP_CYCLES (2)
    ) u_gap (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (g_valid),
        .in_data   (g_data),
        .in_ready  (g_ready),
        .pause     (g_pause),
        .bit_out   (g_bit),
        .bit_valid (g_bvalid),
        .word_done (g_done),
        .busy      (g_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Stream loggers: every valid bit with its cycle number and word_done flag.
    logic a_bits[$];
    int   a_cyc[$];
    logic a_done[$];
    int   a_stray = 0;
    logic g_bits[$];
    int   g_cyc[$];
    logic g_dn[$];
    int   g_stray = 0;

    always @(negedge clk) begin
        if (bit_valid) begin
            a_bits.push_back(bit_out);
            a_cyc.push_back(cyc);
            a_done.push_back(word_done);
        end else if (word_done) begin
            a_stray++;
        end
        if (g_bvalid) begin
            g_bits.push_back(g_bit);
            g_cyc.push_back(cyc);
            g_dn.push_back(g_done);
        end else if (g_done) begin
            g_stray++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        a_bits.delete();
        a_cyc.delete();
        a_done.delete();
        a_stray = 0;
        g_bits.delete();
        g_cyc.delete();
        g_dn.delete();
        g_stray = 0;
    endtask

    // Called and returns at a negedge. Holds the word until it is accepted.
    task automatic push(input bit sel, input logic [7:0] w, output int stalls);
        stalls = 0;
        if (sel) begin
            g_valid = 1'b1;
            g_data  = w;
        end else begin
            in_valid = 1'b1;
            in_data  = w;
        end
        while ((sel ? !g_ready : !in_ready) && stalls < 100) begin
            @(negedge clk);
            stalls++;
        end
        check("push_accept", (stalls < 100), 1'b1);
        @(negedge clk);
        if (sel) g_valid = 1'b0;
        else     in_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit sel, input int budget, output int at_cyc);
        int guard = 0;
        while ((sel ? g_busy : busy) && guard < budget) begin
            @(negedge clk);
            guard++;
        end
        check("idle_reached", (sel ? g_busy : busy), 1'b0);
        at_cyc = cyc;
    endtask

    task automatic check_stream(input bit sel, input string tag, input logic [63:0] exp_bits,
                                input logic [63:0] exp_done, input int n);
        logic [63:0] bits_p = '0;
        logic [63:0] done_p = '0;
        int          sz;
        sz = sel ? g_bits.size() : a_bits.size();
        for (int i = 0; i < sz; i++) begin
            bits_p = {bits_p[62:0], (sel ? g_bits[i] : a_bits[i])};
            done_p = {done_p[62:0], (sel ? g_dn[i] : a_done[i])};
        end
        check({tag, "_len"},   sz, n);
        check({tag, "_bits"},  bits_p, exp_bits);
        check({tag, "_done"},  done_p, exp_done);
        check({tag, "_stray"}, (sel ? g_stray : a_stray), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int stall;
        int stalls[6];
        int idle_at;
        int seen;
        logic [7:0] words[6];

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        pause    = 1'b0;
        g_valid  = 1'b0;
        g_data   = '0;
        g_pause  = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_bit_out",   bit_out,   1'b0);
        check("rst_bit_valid", bit_valid, 1'b0);
        check("rst_word_done", word_done, 1'b0);
        check("rst_in_ready",  in_ready,  1'b1);
        check("rst_busy",      busy,      1'b0);
        reset = 1'b0;
        @(negedge clk);
        clear_logs();

        // Single word 0xB6, MSB first, with latency check
        check("t1_ready", in_ready, 1'b1);
        push(1'b0, 8'hB6, stall);
        check("t1_lat_k", bit_valid, 1'b0);
        @(negedge clk);
        check("t1_lat_k1", bit_valid, 1'b1);
        wait_idle(1'b0, 100, idle_at);
        check("t1_busy_fall", idle_at, a_cyc[7] + 1);
        check("t1_span", a_cyc[7] - a_cyc[0], 7);
        check_stream(1'b0, "t1", 64'hB6, 64'h01, 8);
        @(negedge clk);
        clear_logs();

        // Three back-to-back words, no bubbles
        push(1'b0, 8'hB6, stall);
        push(1'b0, 8'h5A, stall);
        push(1'b0, 8'hFF, stall);
        wait_idle(1'b0, 200, idle_at);
        check("t2_span", a_cyc[23] - a_cyc[0], 23);
        check_stream(1'b0, "t2", 64'hB65AFF, 64'h010101, 24);
        @(negedge clk);
        clear_logs();

        // Six words with in_valid held: the FIFO fills and back-pressures
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 5; i++) begin
            push(1'b0, words[i], stalls[i]);
        end
        check("t3_full_ready", in_ready, 1'b0);
        push(1'b0, words[5], stalls[5]);
        check("t3_early_stalls", stalls[0] + stalls[1] + stalls[2] + stalls[3] + stalls[4], 0);
        check("t3_last_stall", stalls[5], 5);
        wait_idle(1'b0, 300, idle_at);
        check("t3_span", a_cyc[47] - a_cyc[0], 47);
        check_stream(1'b0, "t3", 64'h112233445566, 64'h010101010101, 48);
        @(negedge clk);
        clear_logs();

        // Pause for 3 cycles while the fourth bit is on the line
        push(1'b0, 8'hB6, stall);
        seen = 0;
        for (int i = 0; i < 50 && seen < 4; i++) begin
            @(negedge clk);
            if (bit_valid) seen++;
        end
        pause = 1'b1;
        @(negedge clk);
        check("t4_paused_invalid", bit_valid, 1'b0);
        repeat (2) @(negedge clk);
        pause = 1'b0;
        wait_idle(1'b0, 100, idle_at);
        check("t4_span", a_cyc[7] - a_cyc[0], 10);
        check_stream(1'b0, "t4", 64'hB6, 64'h01, 8);
        @(negedge clk);
        clear_logs();

        // LSB first with a 2-cycle gap between words
        push(1'b1, 8'h01, stall);
        push(1'b1, 8'h80, stall);
        wait_idle(1'b1, 200, idle_at);
        check("t5_w0_span", g_cyc[7] - g_cyc[0], 7);
        check("t5_gap", g_cyc[8] - g_cyc[7], 3);
        check("t5_w1_span", g_cyc[15] - g_cyc[8], 7);
        check_stream(1'b1, "t5", 64'h8001, 64'h0101, 16);
        @(negedge clk);
        clear_logs();

        // Reset mid-word with two words still queued
        push(1'b0, 8'hFF, stall);
        push(1'b0, 8'hC3, stall);
        push(1'b0, 8'h0F, stall);
        seen = 0;
        for (int i = 0; i < 50 && seen < 3; i++) begin
            if (bit_valid) seen++;
            if (seen < 3) @(negedge clk);
        end
        check("t6_pre_busy",  busy,      1'b1);
        check("t6_pre_valid", bit_valid, 1'b1);
        reset = 1'b1;
        #1;
        check("t6_bit_out",   bit_out,   1'b0);
        check("t6_bit_valid", bit_valid, 1'b0);
        check("t6_word_done", word_done, 1'b0);
        check("t6_in_ready",  in_ready,  1'b1);
        check("t6_busy",      busy,      1'b0);
        @(negedge clk);
        reset = 1'b0;
        clear_logs();
        repeat (30) @(negedge clk);
        check("t6_residual_bits", a_bits.size(), 0);
        check("t6_residual_done", a_stray, 0);
        check("t6_busy_after", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
